kronos_rf_sb: RTL and testbench
===============================

Name: kronos_rf_sb

Overview:
- Parametrised successor to the Kronos integer register file and operand stage.
- Holds NREGS registers of XLEN bits with NWR write ports; x0 is hard-wired to zero.
- Latches decoded operands behind a valid/ready handshake, forwarding write-port data both at capture and while held.
- Tracks in-flight destination registers in a scoreboard so the Execute stage sees operand hazards explicitly, and flags register indices illegal for NREGS=16 (RV32E).

Parameters:
XLEN, 32, register and data width
NREGS, 32, architectural register count; 32 (RV32I) or 16 (RV32E)
NWR, 2, number of write ports; higher index has priority

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
flush  input  1  discard held operands
in_vld  input  1  decoded instruction valid
in_rdy  output  1  stage can accept
in_rs1  input  5  rs1 index
in_rs2  input  5  rs2 index
in_rd  input  5  rd index
in_rs1_en  input  1  rs1 is read
in_rs2_en  input  1  rs2 is read
in_rd_en  input  1  rd is written
out_vld  output  1  operands valid
out_rdy  input  1  Execute accepts
out_rs1_data  output  XLEN  rs1 operand
out_rs2_data  output  XLEN  rs2 operand
out_rd  output  5  held rd index
out_rd_en  output  1  held rd enable
out_hazard  output  1  a held operand awaits an in-flight write
out_illegal  output  1  an enabled index is >= NREGS
wr_en  input  NWR  per-port write enable
wr_sel  input  NWR*5  per-port write index
wr_data  input  NWR*XLEN  per-port write data

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0, except in_rdy, which is combinational.
  - The scoreboard goes to all-zero.
  - Register array contents are not reset; x0 reads 0 regardless.
  - Reset mid-operation drops the held instruction and all pending bits.
- Writes:
  - A write takes effect at the clock edge when wr_en[i] is high.
  - Writes to x0 or to any index >= NREGS are ignored.
  - Same-cycle writes to the same register: the highest port index wins.
- Ready:
  - in_rdy = ~flush & (~out_vld | out_rdy).
- Capture (in_vld & in_rdy):
  - out_vld <= 1 at the next edge; latency is 1 cycle.
  - Each operand resolves in this order:
    - 0 if its enable is low or its index is 0;
    - else same-cycle write data (highest-priority matching port);
    - else the array value.
  - out_rd and out_rd_en are latched.
  - out_illegal <= any enabled index >= NREGS. With NREGS=32 this is always 0.
- Hold (out_vld & ~out_rdy, no flush):
  - Each matching write port (non-zero, enabled held index) overwrites the held operand.
  - The matching write also clears that operand's pending flag.
- Drain:
  - out_vld & out_rdy & ~in_vld -> out_vld <= 0.
- Flush:
  - out_vld <= 0 and no capture in that cycle.
  - Scoreboard is unchanged: in-flight writes still return.
- Scoreboard, pend[NREGS]:
  - Set: pend[out_rd] on issue, i.e. out_vld & out_rdy & out_rd_en & out_rd != 0 & out_rd < NREGS.
  - Clear: pend[wr_sel[i]] on any wr_en[i].
  - Same-cycle set and clear of the same register: set wins, because the issuer is younger.
- Pending flags, captured with the operands:
  - rsX_pend = enabled & index != 0 & (pend[idx] & ~cleared-this-cycle | issuing-rd == idx).
  - out_hazard = out_vld & (rs1_pend | rs2_pend). It is combinational from registered flags.
- Downstream must not assert out_rdy while out_hazard is high; the block does not check this.

Test Plan:
- Write x5=0x1234 via port 0, then capture rs1=5, rs2=0 -> out_rs1_data=0x1234, out_rs2_data=0, out_vld=1 one cycle after the handshake.
- Same cycle: capture rs1=7 while port 0 writes x7=0xA and port 1 writes x7=0xB -> out_rs1_data=0xB; array x7=0xB.
- Issue rd=3 (out_rdy=1), then capture rs2=3 -> out_hazard=1. Hold with out_rdy=0 and write x3=0x55 -> next cycle out_rs2_data=0x55, out_hazard=0, pend[3]=0.
- Issue rd=4 on the same edge a port writes x4 -> pend[4] remains 1; a later rs1=4 capture shows out_hazard=1.
- NREGS=16: capture rs1=17 with in_rs1_en=1 -> out_illegal=1. Write to x20 -> ignored, array unchanged.
- out_vld=1, assert flush -> in_rdy=0 and out_vld=0 next cycle, pend bits kept. Assert rst mid-hold -> all outputs 0 immediately, scoreboard cleared.

Source files
------------

// File: rtl/kronos_rf_sb.sv
// kronos_rf_sb - integer register file with operand stage and write scoreboard.
//
// Holds NREGS registers of XLEN bits with NWR write ports. x0 always reads 0.
// Decoded operands are captured behind a valid/ready handshake. Write-port
// data is forwarded into the operands at capture time and while they are held.
// A scoreboard tracks destination registers that are in flight, so Execute
// sees operand hazards directly. Indices >= NREGS are flagged as illegal.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_flush             discard the held operands
//   i_in_*              decoded instruction (rs1/rs2/rd indices and enables),
//                       i_in_vld / o_in_rdy handshake
//   o_out_*             held operands, rd, hazard and illegal flags,
//                       o_out_vld / i_out_rdy handshake
//   i_wr_en/sel/data    NWR write ports, packed; port i uses slice i.
//                       The highest port index has priority.
module kronos_rf_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWR   = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_in_vld,
  output logic                  o_in_rdy,
  input  logic [4:0]            i_in_rs1,
  input  logic [4:0]            i_in_rs2,
  input  logic [4:0]            i_in_rd,
  input  logic                  i_in_rs1_en,
  input  logic                  i_in_rs2_en,
  input  logic                  i_in_rd_en,
  output logic                  o_out_vld,
  input  logic                  i_out_rdy,
  output logic [XLEN-1:0]       o_out_rs1_data,
  output logic [XLEN-1:0]       o_out_rs2_data,
  output logic [4:0]            o_out_rd,
  output logic                  o_out_rd_en,
  output logic                  o_out_hazard,
  output logic                  o_out_illegal,
  input  logic [NWR-1:0]        i_wr_en,
  input  logic [NWR*5-1:0]      i_wr_sel,
  input  logic [NWR*XLEN-1:0]   i_wr_data
);

  localparam int IW = $clog2(NREGS);

  // Index exists in the architectural register file.
  function automatic logic f_in_range(input logic [4:0] idx);
    return int'(idx) < NREGS;
  endfunction

  // Index names a real, writable register (not x0, not out of range).
  function automatic logic f_legal(input logic [4:0] idx);
    return (idx != 5'd0) && f_in_range(idx);
  endfunction

  // Forwarding lookup: returns {hit, data}. The loop runs in ascending port
  // order so the highest matching port index ends up in the result.
  function automatic logic [XLEN:0] f_fwd(
    input logic [4:0]          idx,
    input logic [NWR-1:0]      ok,
    input logic [NWR*5-1:0]    sel,
    input logic [NWR*XLEN-1:0] data
  );
    logic [XLEN:0] res;
    res = '0;
    for (int i = 0; i < NWR; i++) begin
      if (ok[i] && (sel[i*5 +: 5] == idx)) begin
        res = {1'b1, data[i*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_pend;

  logic             r_out_vld;
  logic [XLEN-1:0]  r_rs1_data;
  logic [XLEN-1:0]  r_rs2_data;
  logic [4:0]       r_rs1_idx;
  logic [4:0]       r_rs2_idx;
  logic             r_rs1_chk;
  logic             r_rs2_chk;
  logic             r_rs1_pend;
  logic             r_rs2_pend;
  logic [4:0]       r_out_rd;
  logic             r_out_rd_en;
  logic             r_out_ill;

  logic [NWR-1:0]   w_wr_ok;
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_pend_nxt;
  logic             w_in_rdy;
  logic             w_cap;
  logic             w_hold;
  logic             w_issue;
  logic [XLEN:0]    w_cap_fwd1;
  logic [XLEN:0]    w_cap_fwd2;
  logic [XLEN:0]    w_hold_fwd1;
  logic [XLEN:0]    w_hold_fwd2;
  logic [XLEN-1:0]  w_cap_rs1_data;
  logic [XLEN-1:0]  w_cap_rs2_data;
  logic             w_cap_rs1_pend;
  logic             w_cap_rs2_pend;
  logic             w_cap_ill;
  logic             w_hold_hit1;
  logic             w_hold_hit2;

  // Write ports that actually update the array (x0 and out-of-range dropped).
  always_comb begin
    w_wr_ok = '0;
    for (int i = 0; i < NWR; i++) begin
      w_wr_ok[i] = i_wr_en[i] && f_legal(i_wr_sel[i*5 +: 5]);
    end
  end

  always_comb begin
    w_in_rdy = ~i_flush & (~r_out_vld | i_out_rdy);
    w_cap    = i_in_vld & w_in_rdy;
    w_hold   = r_out_vld & ~i_out_rdy & ~i_flush;
    w_issue  = r_out_vld & i_out_rdy & r_out_rd_en & f_legal(r_out_rd);
  end

  // Scoreboard: returning writes clear, issue sets. Set is applied last so it
  // wins over a same-cycle clear; the issuing instruction is the younger one.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NWR; i++) begin
      if (i_wr_en[i] && f_in_range(i_wr_sel[i*5 +: 5])) begin
        w_clr[i_wr_sel[i*5 +: IW]] = 1'b1;
      end
    end
    w_set = '0;
    if (w_issue) begin
      w_set[r_out_rd[IW-1:0]] = 1'b1;
    end
    w_pend_nxt = (r_pend & ~w_clr) | w_set;
  end

  // Operand resolution at capture: zero, then forwarded write, then array.
  always_comb begin
    w_cap_fwd1     = f_fwd(i_in_rs1, w_wr_ok, i_wr_sel, i_wr_data);
    w_cap_fwd2     = f_fwd(i_in_rs2, w_wr_ok, i_wr_sel, i_wr_data);
    w_cap_rs1_data = '0;
    w_cap_rs2_data = '0;
    if (i_in_rs1_en && f_legal(i_in_rs1)) begin
      w_cap_rs1_data = w_cap_fwd1[XLEN] ? w_cap_fwd1[XLEN-1:0]
                                        : r_regs[i_in_rs1[IW-1:0]];
    end
    if (i_in_rs2_en && f_legal(i_in_rs2)) begin
      w_cap_rs2_data = w_cap_fwd2[XLEN] ? w_cap_fwd2[XLEN-1:0]
                                        : r_regs[i_in_rs2[IW-1:0]];
    end
  end

  // Pending at capture: still pending after this cycle's returns, or it is
  // the rd being issued on this very edge.
  always_comb begin
    w_cap_rs1_pend = 1'b0;
    w_cap_rs2_pend = 1'b0;
    if (i_in_rs1_en && f_legal(i_in_rs1)) begin
      w_cap_rs1_pend = (r_pend[i_in_rs1[IW-1:0]] && !w_clr[i_in_rs1[IW-1:0]])
                       || (w_issue && (r_out_rd == i_in_rs1));
    end
    if (i_in_rs2_en && f_legal(i_in_rs2)) begin
      w_cap_rs2_pend = (r_pend[i_in_rs2[IW-1:0]] && !w_clr[i_in_rs2[IW-1:0]])
                       || (w_issue && (r_out_rd == i_in_rs2));
    end
    w_cap_ill = (i_in_rs1_en && !f_in_range(i_in_rs1))
                || (i_in_rs2_en && !f_in_range(i_in_rs2))
                || (i_in_rd_en  && !f_in_range(i_in_rd));
  end

  // Forwarding into held operands; r_rsX_chk already excludes x0/out-of-range.
  always_comb begin
    w_hold_fwd1 = f_fwd(r_rs1_idx, w_wr_ok, i_wr_sel, i_wr_data);
    w_hold_fwd2 = f_fwd(r_rs2_idx, w_wr_ok, i_wr_sel, i_wr_data);
    w_hold_hit1 = r_rs1_chk & w_hold_fwd1[XLEN];
    w_hold_hit2 = r_rs2_chk & w_hold_fwd2[XLEN];
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NWR; i++) begin
      if (w_wr_ok[i]) begin
        r_regs[i_wr_sel[i*5 +: IW]] <= i_wr_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pend      <= '0;
      r_out_vld   <= 1'b0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_rs1_idx   <= '0;
      r_rs2_idx   <= '0;
      r_rs1_chk   <= 1'b0;
      r_rs2_chk   <= 1'b0;
      r_rs1_pend  <= 1'b0;
      r_rs2_pend  <= 1'b0;
      r_out_rd    <= '0;
      r_out_rd_en <= 1'b0;
      r_out_ill   <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      if (i_flush) begin
        r_out_vld <= 1'b0;
      end else if (w_cap) begin
        r_out_vld   <= 1'b1;
        r_rs1_data  <= w_cap_rs1_data;
        r_rs2_data  <= w_cap_rs2_data;
        r_rs1_idx   <= i_in_rs1;
        r_rs2_idx   <= i_in_rs2;
        r_rs1_chk   <= i_in_rs1_en && f_legal(i_in_rs1);
        r_rs2_chk   <= i_in_rs2_en && f_legal(i_in_rs2);
        r_rs1_pend  <= w_cap_rs1_pend;
        r_rs2_pend  <= w_cap_rs2_pend;
        r_out_rd    <= i_in_rd;
        r_out_rd_en <= i_in_rd_en;
        r_out_ill   <= w_cap_ill;
      end else if (w_hold) begin
        if (w_hold_hit1) begin
          r_rs1_data <= w_hold_fwd1[XLEN-1:0];
          r_rs1_pend <= 1'b0;
        end
        if (w_hold_hit2) begin
          r_rs2_data <= w_hold_fwd2[XLEN-1:0];
          r_rs2_pend <= 1'b0;
        end
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign o_in_rdy       = w_in_rdy;
  assign o_out_vld      = r_out_vld;
  assign o_out_rs1_data = r_rs1_data;
  assign o_out_rs2_data = r_rs2_data;
  assign o_out_rd       = r_out_rd;
  assign o_out_rd_en    = r_out_rd_en;
  assign o_out_illegal  = r_out_ill;
  assign o_out_hazard   = r_out_vld & (r_rs1_pend | r_rs2_pend);

endmodule

// File: tb/tb_kronos_rf_sb.sv
module tb_kronos_rf_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int NWR   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                flush, in_vld, in_rdy, in_rs1_en, in_rs2_en, in_rd_en;
  logic [4:0]          in_rs1, in_rs2, in_rd;
  logic                out_vld, out_rdy, out_rd_en, out_hazard, out_illegal;
  logic [XLEN-1:0]     out_rs1_data, out_rs2_data;
  logic [4:0]          out_rd;
  logic [NWR-1:0]      wr_en;
  logic [NWR*5-1:0]    wr_sel;
  logic [NWR*XLEN-1:0] wr_data;

  kronos_rf_sb #(.XLEN(XLEN), .NREGS(NREGS), .NWR(NWR)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_vld(in_vld), .o_in_rdy(in_rdy),
    .i_in_rs1(in_rs1), .i_in_rs2(in_rs2), .i_in_rd(in_rd),
    .i_in_rs1_en(in_rs1_en), .i_in_rs2_en(in_rs2_en), .i_in_rd_en(in_rd_en),
    .o_out_vld(out_vld), .i_out_rdy(out_rdy),
    .o_out_rs1_data(out_rs1_data), .o_out_rs2_data(out_rs2_data),
    .o_out_rd(out_rd), .o_out_rd_en(out_rd_en),
    .o_out_hazard(out_hazard), .o_out_illegal(out_illegal),
    .i_wr_en(wr_en), .i_wr_sel(wr_sel), .i_wr_data(wr_data)
  );

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  rd;
    logic        rd_en;
    logic        ill;
    logic        haz;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_vld;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  bit          m_e1, m_e2, m_rde, m_ill, m_p1, m_p2;
  logic [31:0] m_d1, m_d2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [4:0] idx);
    return (idx != 0) && (int'(idx) < NREGS);
  endfunction

  function automatic bit oor(input logic [4:0] idx);
    return int'(idx) >= NREGS;
  endfunction

  // Advance the model over the coming clock edge using the current inputs.
  task automatic model_step();
    logic [31:0] wd [32];
    bit          wv [32];
    bit          clr [32];
    bit          issue, rdy, cap;
    logic [4:0]  s, old_rd;
    for (int j = 0; j < 32; j++) begin
      wd[j] = '0; wv[j] = 0; clr[j] = 0;
    end
    for (int i = 0; i < NWR; i++) begin
      if (wr_en[i]) begin
        s = wr_sel[i*5 +: 5];
        clr[s] = 1;
        if (legal(s)) begin
          wv[s] = 1;
          wd[s] = wr_data[i*XLEN +: XLEN];
        end
      end
    end
    old_rd = m_rd;
    issue  = m_vld && out_rdy && m_rde && legal(m_rd);
    rdy    = !flush && (!m_vld || out_rdy);
    cap    = in_vld && rdy;
    if (flush) begin
      m_vld = 0;
    end else if (cap) begin
      m_vld = 1;
      m_rs1 = in_rs1; m_e1 = in_rs1_en;
      m_rs2 = in_rs2; m_e2 = in_rs2_en;
      m_rd  = in_rd;  m_rde = in_rd_en;
      m_d1 = (!m_e1 || !legal(m_rs1)) ? 32'h0 : (wv[m_rs1] ? wd[m_rs1] : m_regs[m_rs1]);
      m_d2 = (!m_e2 || !legal(m_rs2)) ? 32'h0 : (wv[m_rs2] ? wd[m_rs2] : m_regs[m_rs2]);
      m_p1 = m_e1 && legal(m_rs1) && ((m_pend[m_rs1] && !clr[m_rs1]) || (issue && old_rd == m_rs1));
      m_p2 = m_e2 && legal(m_rs2) && ((m_pend[m_rs2] && !clr[m_rs2]) || (issue && old_rd == m_rs2));
      m_ill = (m_e1 && oor(m_rs1)) || (m_e2 && oor(m_rs2)) || (m_rde && oor(m_rd));
    end else if (m_vld && !out_rdy) begin
      if (m_e1 && legal(m_rs1) && wv[m_rs1]) begin m_d1 = wd[m_rs1]; m_p1 = 0; end
      if (m_e2 && legal(m_rs2) && wv[m_rs2]) begin m_d2 = wd[m_rs2]; m_p2 = 0; end
    end else begin
      m_vld = 0;
    end
    for (int j = 0; j < 32; j++) begin
      if (clr[j]) m_pend[j] = 0;
      if (wv[j]) m_regs[j] = wd[j];
    end
    if (issue) m_pend[old_rd] = 1;
    if (m_vld) q.push_back('{m_d1, m_d2, m_rd, m_rde, m_ill, m_p1 | m_p2});
  endtask

  // Monitor: whenever the DUT presents operands, pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_vld) begin
        if (q.size() == 0) begin
          check("out_vld_unexpected", out_vld, 0);
        end else begin
          e = q.pop_front();
          check("rs1_data", out_rs1_data, e.d1);
          check("rs2_data", out_rs2_data, e.d2);
          check("rd",       out_rd,       e.rd);
          check("rd_en",    out_rd_en,    e.rd_en);
          check("illegal",  out_illegal,  e.ill);
          check("hazard",   out_hazard,   e.haz);
        end
      end
    end
  end

  task automatic idle();
    in_vld = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_en = 0; in_rs2_en = 0; in_rd_en = 0;
    flush = 0; out_rdy = 1; wr_en = '0; wr_sel = '0; wr_data = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] sel, input logic [31:0] d);
    wr_en[p] = 1'b1;
    wr_sel[p*5 +: 5] = sel;
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic cap(input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                     input logic e2, input logic [4:0] rd, input logic rde);
    in_vld = 1; in_rs1 = r1; in_rs1_en = e1; in_rs2 = r2; in_rs2_en = e2;
    in_rd = rd; in_rd_en = rde;
  endtask

  // Called just after a falling edge with inputs set; ends at the next one.
  task automatic tick();
    bit exp_rdy;
    #1;
    exp_rdy = !flush && (!m_vld || out_rdy);
    check("in_rdy", in_rdy, exp_rdy);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    check("rst_out_vld", out_vld, 0);
    check("rst_rs1_data", out_rs1_data, 0);
    check("rst_rs2_data", out_rs2_data, 0);
    check("rst_rd", {out_rd, out_rd_en}, 0);
    check("rst_illegal", out_illegal, 0);
    check("rst_hazard", out_hazard, 0);
    m_vld = 0;
    for (int j = 0; j < 32; j++) m_pend[j] = 0;
    @(negedge clk);
    rst = 0;
  endtask

  function automatic logic [4:0] rnd_idx();
    return ($urandom % 8 == 0) ? 5'($urandom % 32) : 5'($urandom % 16);
  endfunction

  initial begin
    int pl[$];
    logic [4:0] s;
    m_vld = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
    m_e1 = 0; m_e2 = 0; m_rde = 0; m_ill = 0; m_p1 = 0; m_p2 = 0;
    m_d1 = 0; m_d2 = 0;
    for (int j = 0; j < 32; j++) begin m_regs[j] = 0; m_pend[j] = 0; end
    idle();
    @(negedge clk);
    do_reset();

    // Give every register a known value.
    for (int k = 1; k < 16; k += 2) begin
      idle();
      wr(0, 5'(k), 32'h100 + k);
      if (k + 1 < 16) wr(1, 5'(k + 1), 32'h100 + k + 1);
      tick();
    end

    // Basic write then read.
    idle(); wr(0, 5, 32'h1234); tick();
    idle(); cap(5, 1, 0, 1, 0, 0); tick();
    idle(); tick();

    // Same-cycle writes to one register: port 1 wins, also in the array.
    idle(); cap(7, 1, 0, 0, 0, 0); wr(0, 7, 32'hA); wr(1, 7, 32'hB); tick();
    idle(); tick();
    idle(); cap(7, 1, 0, 0, 0, 0); tick();
    idle(); tick();

    // Issue rd=3, capture rs2=3 -> hazard, resolved by write during hold.
    idle(); cap(0, 0, 0, 0, 3, 1); tick();
    idle(); cap(0, 0, 3, 1, 0, 0); tick();
    idle(); out_rdy = 0; wr(0, 3, 32'h55); tick();
    idle(); out_rdy = 0; tick();
    idle(); tick();

    // Issue rd=4 on the edge x4 is written: set wins.
    idle(); cap(0, 0, 0, 0, 4, 1); tick();
    idle(); wr(0, 4, 32'h44); tick();
    idle(); cap(4, 1, 0, 0, 0, 0); tick();
    idle(); out_rdy = 0; wr(1, 4, 32'h45); tick();
    idle(); tick();

    // Out-of-range indices.
    idle(); cap(17, 1, 0, 0, 0, 0); tick();
    idle(); wr(0, 20, 32'hDEAD); tick();
    idle(); cap(4, 1, 20, 1, 0, 0); tick();
    idle(); tick();

    // Flush keeps the scoreboard.
    idle(); cap(0, 0, 0, 0, 6, 1); tick();
    idle(); cap(9, 1, 0, 0, 0, 0); tick();
    idle(); flush = 1; out_rdy = 0; cap(2, 1, 0, 0, 0, 0); tick();
    idle(); cap(6, 1, 0, 0, 0, 0); tick();
    idle(); out_rdy = 0; wr(0, 6, 32'h66); tick();
    idle(); tick();

    // Reset while holding clears everything.
    idle(); cap(0, 0, 0, 0, 8, 1); tick();
    idle(); cap(2, 1, 0, 0, 0, 0); tick();
    idle(); out_rdy = 0; tick();
    idle(); out_rdy = 0; do_reset();
    idle(); cap(8, 1, 0, 0, 0, 0); tick();
    idle(); tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      idle();
      in_vld = ($urandom % 4) != 0;
      in_rs1 = rnd_idx(); in_rs1_en = $urandom % 2;
      in_rs2 = rnd_idx(); in_rs2_en = $urandom % 2;
      in_rd  = rnd_idx(); in_rd_en  = $urandom % 2;
      pl.delete();
      for (int j = 1; j < 16; j++) if (m_pend[j]) pl.push_back(j);
      for (int p = 0; p < NWR; p++) begin
        if ($urandom % 2) begin
          s = rnd_idx();
          if (pl.size() > 0 && ($urandom % 2)) s = 5'(pl[$urandom % pl.size()]);
          wr(p, s, $urandom);
        end
      end
      flush = ($urandom % 20) == 0;
      out_rdy = (m_vld && (m_p1 || m_p2)) ? 1'b0 : (($urandom % 3) != 0);
      tick();
    end

    idle(); in_vld = 0; tick();
    idle(); tick();
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
